// File: rtl/l1_sram_buf_if.sv
// l1_sram_buf_if: read/write port bundle for the L1 row buffer.
//   master : loader / sequencer side (drives requests, receives read row + error flag)
//   slave  : buffer side
// Signals:
//   read_en, read_addr            read request and row address
//   read_data, read_valid         registered row, valid one cycle after read_en
//   write_en, write_addr          write request and row address
//   write_data, write_mask        row data and per-lane write enables
//   addr_err                      registered pulse after an out-of-range access
interface l1_sram_buf_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int LANE_W = 8
);
    logic                       read_en;
    logic [ADDR_W-1:0]          read_addr;
    logic [DATA_W-1:0]          read_data;
    logic                       read_valid;
    logic                       write_en;
    logic [ADDR_W-1:0]          write_addr;
    logic [DATA_W-1:0]          write_data;
    logic [DATA_W/LANE_W-1:0]   write_mask;
    logic                       addr_err;

    modport master (
        output read_en, read_addr, write_en, write_addr, write_data, write_mask,
        input  read_data, read_valid, addr_err
    );

    modport slave (
        input  read_en, read_addr, write_en, write_addr, write_data, write_mask,
        output read_data, read_valid, addr_err
    );
endinterface

// File: rtl/l1_sram_buf.sv
// l1_sram_buf: L1 on-chip row buffer (used as ACT_BUF and WEI_BUF).
// Stores DEPTH rows of DATA_W bits; one full row read and one lane-masked
// row write per cycle, read latency one cycle, write-first on collision.
// Ports:
//   core_clk  single clock for read and write
//   rst       synchronous reset, active-high (clears outputs, not mem)
//   bus       l1_sram_buf_if.slave: read/write requests, read row, addr_err
module l1_sram_buf #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int LANE_W = 8
) (
    input  logic          core_clk,
    input  logic          rst,
    l1_sram_buf_if.slave  bus
);
    localparam int              LANES   = DATA_W / LANE_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Name is fixed: benches preload this array directly.
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              rd_ok, wr_ok, collide;
    logic [DATA_W-1:0] rd_row;

    always_comb begin
        rd_ok   = ({1'b0, bus.read_addr}  < DEPTH_C);
        wr_ok   = ({1'b0, bus.write_addr} < DEPTH_C);
        collide = bus.read_en && bus.write_en && rd_ok && wr_ok &&
                  (bus.read_addr == bus.write_addr);

        // Out-of-range reads return zero; collide already implies rd_ok.
        rd_row = '0;
        if (rd_ok) begin
            rd_row = mem[bus.read_addr];
        end
        // Write-first: bypass the lanes being written this cycle.
        for (int unsigned l = 0; l < LANES; l++) begin
            if (collide && bus.write_mask[l]) begin
                rd_row[l*LANE_W +: LANE_W] = bus.write_data[l*LANE_W +: LANE_W];
            end
        end

        read_data_d  = bus.read_en ? rd_row : read_data_q;
        read_valid_d = bus.read_en;
        addr_err_d   = (bus.read_en && !rd_ok) || (bus.write_en && !wr_ok);
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Storage has no reset so preloaded contents survive rst.
    always_ff @(posedge core_clk) begin
        if (!rst && bus.write_en && wr_ok) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (bus.write_mask[l]) begin
                    mem[bus.write_addr][l*LANE_W +: LANE_W] <= bus.write_data[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
    assign bus.addr_err   = addr_err_q;
endmodule

// File: tb/tb_l1_sram_buf.sv
// tb_l1_sram_buf: scoreboard bench for l1_sram_buf (DEPTH=12, ADDR_W=4,
// DATA_W=128, LANE_W=8). Every driven cycle pushes the expected
// {read_valid, addr_err, read_data} seen after that edge; a negedge
// monitor pops and compares.
module tb_l1_sram_buf;
    localparam int DW  = 128;
    localparam int AW  = 4;
    localparam int DEP = 12;
    localparam int LW  = 8;
    localparam int NL  = DW / LW;

    logic core_clk = 1'b0;
    logic rst      = 1'b1;

    l1_sram_buf_if #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) bus ();

    l1_sram_buf #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LANE_W(LW)) dut (
        .core_clk (core_clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        bit          v;
        bit          e;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          q[$];
    int            errors = 0;
    int            checks = 0;

    // Reference model: plain row array; the write is applied before the
    // read is looked up, which is exactly the write-first rule.
    logic [DW-1:0] mdl [0:DEP-1];
    logic [DW-1:0] last_d = '0;

    task automatic step(input bit r, input bit re, input int ra,
                        input bit we, input int wa,
                        input logic [DW-1:0] wd, input logic [NL-1:0] wm);
        exp_t x;
        rst            = r;
        bus.read_en    = re;
        bus.read_addr  = AW'(ra);
        bus.write_en   = we;
        bus.write_addr = AW'(wa);
        bus.write_data = wd;
        bus.write_mask = wm;
        @(posedge core_clk);
        if (r) begin
            last_d = '0;
            x.v = 1'b0;
            x.e = 1'b0;
        end else begin
            if (we && wa < DEP) begin
                for (int l = 0; l < NL; l++)
                    if (wm[l]) mdl[wa][l*LW +: LW] = wd[l*LW +: LW];
            end
            x.e = (re && ra >= DEP) || (we && wa >= DEP);
            x.v = re;
            if (re) last_d = (ra < DEP) ? mdl[ra] : '0;
        end
        x.d = last_d;
        q.push_back(x);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [NL-1:0] m);
        step(0, 0, 0, 1, a, d, m);
    endtask

    task automatic rd(input int a);
        step(0, 1, a, 0, 0, '0, '0);
    endtask

    function automatic logic [DW-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge core_clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (bus.read_valid !== x.v) begin
                errors++;
                $display("FAIL read_valid t=%0t got=%b exp=%b", $time, bus.read_valid, x.v);
            end
            checks++;
            if (bus.addr_err !== x.e) begin
                errors++;
                $display("FAIL addr_err t=%0t got=%b exp=%b", $time, bus.addr_err, x.e);
            end
            checks++;
            if (bus.read_data !== x.d) begin
                errors++;
                $display("FAIL read_data t=%0t got=%h exp=%h", $time, bus.read_data, x.d);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEP; i++) mdl[i] = '0;

        // Reset state.
        step(1, 0, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, 0, '0, '0);

        // Preload every row; rows 0..3 with the recognisable pattern.
        for (int i = 0; i < DEP; i++) begin
            if (i < 4) wr(i, {NL{8'(i * 8'h11)}}, '1);
            else       wr(i, rnd_row(), '1);
        end
        rd(2);
        step(0, 0, 0, 0, 0, '0, '0);          // read_data holds, valid drops

        // Write/read back.
        wr(5, 128'hDEADBEEF, '1);
        rd(5);

        // Masked write of lane 0 only.
        wr(7, '1, '1);
        wr(7, '0, 16'h0001);
        rd(7);

        // Same-cycle collision, full mask and partial mask.
        wr(9, 128'hAAAA, '1);
        step(0, 1, 9, 1, 9, 128'h5555, '1);
        step(0, 1, 9, 1, 9, {NL{8'h3C}}, 16'hA5F0);

        // Reset mid-operation: requests ignored, row 3 keeps its contents.
        step(1, 1, 3, 1, 3, rnd_row(), '1);
        rd(3);

        // Out of range: dropped write, zero read, consecutive errors.
        wr(13, rnd_row(), '1);
        step(0, 0, 0, 0, 0, '0, '0);
        rd(13);
        rd(15);
        step(0, 1, 12, 1, 14, rnd_row(), '1);
        step(0, 0, 0, 0, 0, '0, '0);
        rd(1);

        // Randomised traffic, biased toward collisions.
        for (int n = 0; n < 1500; n++) begin
            bit            r, re, we;
            int            ra, wa;
            logic [NL-1:0] wm;
            r  = ($urandom_range(0, 63) == 0);
            re = $urandom_range(0, 3) != 0;
            we = $urandom_range(0, 2) != 0;
            ra = $urandom_range(0, 13);
            wa = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 13));
            wm = ($urandom_range(0, 3) == 0) ? '1 : NL'($urandom);
            step(r, re, ra, we, wa, rnd_row(), wm);
        end
        step(0, 0, 0, 0, 0, '0, '0);

        // Drain with a bounded wait.
        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge core_clk);
        @(negedge core_clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
